// File: rtl/rx_chars_pkg.sv
// ============================================================================
// Module   : rx_chars_pkg
// Purpose  : Shared state encodings and character constants for the
//            character-receive controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_chars_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WAIT    = 3'd1;
    localparam logic [2:0] c_ST_STORE   = 3'd2;
    localparam logic [2:0] c_ST_ADVANCE = 3'd3;
    localparam logic [2:0] c_ST_ECHO    = 3'd4;
    localparam logic [2:0] c_ST_FINISH  = 3'd5;

    localparam logic [7:0] c_CR   = 8'h0D;
    localparam logic [6:0] c_NULL = 7'h00;

endpackage

`default_nettype wire

// File: rtl/rx_start_edge.sv
// ============================================================================
// Module   : rx_start_edge
// Purpose  : Two-flop synchroniser for the Start level followed by a
//            rising-edge one-shot producing a single-cycle StartPulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_start_edge (
    input  logic clock,
    input  logic reset,
    input  logic Start,
    output logic StartPulse
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync     <= 2'b00;
            r_prev     <= 1'b0;
            StartPulse <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], Start};
            r_prev     <= r_sync[1];
            StartPulse <= r_sync[1] & ~r_prev;
        end
    end

endmodule

`default_nettype wire

// File: rtl/receive_chars.sv
// ============================================================================
// Module   : receive_chars
// Purpose  : Pops characters from the UART rx FIFO into character memory from
//            address 0 until CR or buffer full, then writes a NULL terminator.
//            Optional echo of stored characters when RX_ECHO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module receive_chars #(
    parameter int AddressBits = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   Start,
    input  logic                   rx_empty,
    input  logic [7:0]             rx_data,
    output logic                   read_uart,
    output logic                   mem_write,
    output logic [AddressBits-1:0] Address,
    output logic [6:0]             mem_data,
    output logic                   Receiving,
    output logic                   Done,
    output logic                   Overflow,
    output logic [AddressBits-1:0] Count,
    input  logic                   tx_full,
    output logic                   write_to_uart,
    output logic [7:0]             tx_data
);

    import rx_chars_pkg::*;

    localparam logic [AddressBits-1:0] c_LAST = '1;

    logic       w_start_pulse;
    logic [2:0] r_state;
    logic [7:0] r_char;
    logic       r_term;

    rx_start_edge u_start_edge (
        .clock      (clock),
        .reset      (reset),
        .Start      (Start),
        .StartPulse (w_start_pulse)
    );

`ifndef RX_ECHO_EN
    logic w_unused_tx_full;
    assign w_unused_tx_full = tx_full;
    assign write_to_uart    = 1'b0;
    assign tx_data          = 8'h00;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_char    <= 8'h00;
            r_term    <= 1'b0;
            read_uart <= 1'b0;
            mem_write <= 1'b0;
            Address   <= '0;
            mem_data  <= c_NULL;
            Receiving <= 1'b0;
            Done      <= 1'b0;
            Overflow  <= 1'b0;
            Count     <= '0;
`ifdef RX_ECHO_EN
            write_to_uart <= 1'b0;
            tx_data       <= 8'h00;
`endif
        end else begin
            read_uart <= 1'b0;
            mem_write <= 1'b0;
            Done      <= 1'b0;
`ifdef RX_ECHO_EN
            write_to_uart <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_pulse) begin
                        Address   <= '0;
                        Count     <= '0;
                        Overflow  <= 1'b0;
                        Receiving <= 1'b1;
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (!rx_empty) begin
                        r_char  <= rx_data;
                        r_state <= c_ST_STORE;
                    end
                end
                c_ST_STORE: begin
                    read_uart <= 1'b1;
                    mem_write <= 1'b1;
                    // The last location is reserved for NULL, so a char landing there is dropped.
                    if (r_char == c_CR) begin
                        mem_data <= c_NULL;
                        r_term   <= 1'b1;
                    end else if (Address == c_LAST) begin
                        mem_data <= c_NULL;
                        Overflow <= 1'b1;
                        r_term   <= 1'b1;
                    end else begin
                        mem_data <= r_char[6:0];
                        r_term   <= 1'b0;
                    end
                    r_state <= c_ST_ADVANCE;
                end
                c_ST_ADVANCE: begin
                    if (r_term) begin
`ifdef RX_ECHO_EN
                        r_state <= (r_char == c_CR) ? c_ST_ECHO : c_ST_FINISH;
`else
                        r_state <= c_ST_FINISH;
`endif
                    end else begin
                        Address <= Address + 1'b1;
                        Count   <= Count + 1'b1;
`ifdef RX_ECHO_EN
                        r_state <= c_ST_ECHO;
`else
                        r_state <= c_ST_WAIT;
`endif
                    end
                end
`ifdef RX_ECHO_EN
                c_ST_ECHO: begin
                    if (!tx_full) begin
                        write_to_uart <= 1'b1;
                        tx_data       <= r_char;
                        r_state       <= r_term ? c_ST_FINISH : c_ST_WAIT;
                    end
                end
`endif
                c_ST_FINISH: begin
                    Receiving <= 1'b0;
                    Done      <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
